// File: rtl/tb_mem_arb_pkg.sv
// Shared types for the two-master data-side RAM arbiter.
package tb_mem_arb_pkg;

    localparam int NUM_MASTERS = 2;

    // Master identifiers as stored in the in-flight ID FIFO.
    typedef enum logic {
        MST_CORE = 1'b0,
        MST_DBG  = 1'b1
    } master_id_t;

    // Request payload at the default 32-bit address/data widths.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    // The master that receives priority after a grant to 'id'.
    function automatic master_id_t other_master(input master_id_t id);
        return (id == MST_CORE) ? MST_DBG : MST_CORE;
    endfunction

endpackage

// File: rtl/tb_mem_arb_id_fifo.sv
// In-order FIFO of master IDs, one entry per transaction the RAM has granted
// but not yet answered. A push while full or a pop while empty is ignored.
module tb_mem_arb_id_fifo
    import tb_mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  master_id_t i_push_id,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output master_id_t o_head
);

    // A depth of 1 still gets a 1-bit pointer; it simply never leaves 0.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    master_id_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage, written at the tail on push.
    always_ff @(posedge i_clk) begin
        // NOTE: storage is deliberately not reset; the occupancy count alone decides which entries are valid.
        if (w_push) r_mem[r_wr_ptr] <= i_push_id;
    end

endmodule

// File: rtl/tb_mem_arbiter.sv
// Two-master round-robin arbiter in front of the single data-side RAM port.
// Master 0 is the core LSU, master 1 the debug system-bus master. Grants are
// same-cycle; responses are routed back in grant order via an ID FIFO.
// Optional feature macro: TB_MEM_ARB_PERF_CNT_EN adds saturating grant and
// stall counters.
module tb_mem_arbiter
    import tb_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,

`ifdef TB_MEM_ARB_PERF_CNT_EN
    output logic [31:0]             m0_grant_cnt_o,
    output logic [31:0]             m1_grant_cnt_o,
    output logic [31:0]             stall_cnt_o,
`endif
    output logic                    err_o
);

    logic [NUM_MASTERS-1:0] w_req;
    logic                   w_any_req;
    master_id_t             w_sel;
    logic                   w_hs;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    master_id_t             w_fifo_head;

    master_id_t             r_prio;
    logic                   r_lock;
    master_id_t             r_lock_id;
    logic                   r_err;

    assign w_req     = {m1_req_i, m0_req_i};
    assign w_any_req = |w_req;

    // Pick the master to forward: a locked (stalled) master first, then the
    // only requester, then the priority holder on contention.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_sel = MST_CORE;
        if (r_lock)                    w_sel = r_lock_id;
        else if (w_req == 2'b01)       w_sel = MST_CORE;
        else if (w_req == 2'b10)       w_sel = MST_DBG;
        else if (w_req == 2'b11)       w_sel = r_prio;
    end

    // Forward the selected payload; zero when nobody requests.
    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (w_any_req) begin
            if (w_sel == MST_DBG) begin
                s_addr_o  = m1_addr_i;
                s_we_o    = m1_we_i;
                s_be_o    = m1_be_i;
                s_wdata_o = m1_wdata_i;
            end else begin
                s_addr_o  = m0_addr_i;
                s_we_o    = m0_we_i;
                s_be_o    = m0_be_i;
                s_wdata_o = m0_wdata_i;
            end
        end
    end

    // A full FIFO blocks new requests even if a response pops it this cycle,
    // and nothing is granted or delivered while reset is asserted.
    assign s_req_o  = w_any_req & ~w_fifo_full & ~rst_i;
    assign w_hs     = s_req_o & s_gnt_i;
    assign m0_gnt_o = w_hs & (w_sel == MST_CORE);
    assign m1_gnt_o = w_hs & (w_sel == MST_DBG);

    assign w_pop       = s_rvalid_i & ~w_fifo_empty & ~rst_i;
    assign m0_rvalid_o = w_pop & (w_fifo_head == MST_CORE);
    assign m1_rvalid_o = w_pop & (w_fifo_head == MST_DBG);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_o       = r_err;

    // Round-robin pointer and stall lock: a stalled request keeps its
    // payload on the bus until the RAM accepts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio    <= MST_CORE;
            r_lock    <= 1'b0;
            r_lock_id <= MST_CORE;
        end else if (w_hs) begin
            r_prio <= other_master(w_sel);
            r_lock <= 1'b0;
        end else if (s_req_o) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_sel;
        end
    end

    // Sticky error for a response with nothing outstanding.
    always_ff @(posedge clk_i) begin
        if (rst_i)                          r_err <= 1'b0;
        else if (s_rvalid_i & w_fifo_empty) r_err <= 1'b1;
    end

    tb_mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_push    (w_hs),
        .i_push_id (w_sel),
        .i_pop     (w_pop),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_head    (w_fifo_head)
    );

`ifdef TB_MEM_ARB_PERF_CNT_EN
    logic [31:0] r_m0_grant_cnt;
    logic [31:0] r_m1_grant_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating per-master grant counters and a stall-cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m0_grant_cnt <= '0;
            r_m1_grant_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (m0_gnt_o && r_m0_grant_cnt != '1) r_m0_grant_cnt <= r_m0_grant_cnt + 32'd1;
            if (m1_gnt_o && r_m1_grant_cnt != '1) r_m1_grant_cnt <= r_m1_grant_cnt + 32'd1;
            if (w_any_req && !w_hs && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign m0_grant_cnt_o = r_m0_grant_cnt;
    assign m1_grant_cnt_o = r_m1_grant_cnt;
    assign stall_cnt_o    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Directed bench for tb_mem_arbiter (default build, MAX_OUTSTANDING = 2).
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well clear of the rising edge that commits state.
module tb_tb_mem_arbiter;
    import tb_mem_arb_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        m0_req_i,  m1_req_i;
    logic        m0_gnt_o,  m1_gnt_o;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_we_i,   m1_we_i;
    logic [3:0]  m0_be_i,   m1_be_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o;
    logic        s_gnt_i;
    logic [31:0] s_addr_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_wdata_o;
    logic        s_rvalid_i;
    logic [31:0] s_rdata_i;
    logic        err_o;
`ifdef TB_MEM_ARB_PERF_CNT_EN
    logic [31:0] m0_grant_cnt_o, m1_grant_cnt_o, stall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    tb_mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_addr_i   (m0_addr_i),
        .m0_we_i     (m0_we_i),
        .m0_be_i     (m0_be_i),
        .m0_wdata_i  (m0_wdata_i),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_addr_i   (m1_addr_i),
        .m1_we_i     (m1_we_i),
        .m1_be_i     (m1_be_i),
        .m1_wdata_i  (m1_wdata_i),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .s_req_o     (s_req_o),
        .s_gnt_i     (s_gnt_i),
        .s_addr_o    (s_addr_o),
        .s_we_o      (s_we_o),
        .s_be_o      (s_be_o),
        .s_wdata_o   (s_wdata_o),
        .s_rvalid_i  (s_rvalid_i),
        .s_rdata_i   (s_rdata_i),
`ifdef TB_MEM_ARB_PERF_CNT_EN
        .m0_grant_cnt_o (m0_grant_cnt_o),
        .m1_grant_cnt_o (m1_grant_cnt_o),
        .stall_cnt_o    (stall_cnt_o),
`endif
        .err_o       (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_idle();
        m0_req_i = 1'b0; m0_addr_i = '0; m0_we_i = 1'b0; m0_be_i = '0; m0_wdata_i = '0;
        m1_req_i = 1'b0; m1_addr_i = '0; m1_we_i = 1'b0; m1_be_i = '0; m1_wdata_i = '0;
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    endtask

    task automatic drive_m0(input logic req, input obi_req_t r);
        m0_req_i = req; m0_addr_i = r.addr; m0_we_i = r.we; m0_be_i = r.be; m0_wdata_i = r.wdata;
    endtask

    task automatic drive_m1(input logic req, input obi_req_t r);
        m1_req_i = req; m1_addr_i = r.addr; m1_we_i = r.we; m1_be_i = r.be; m1_wdata_i = r.wdata;
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        next_cycle();
        set_idle();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        obi_req_t rq;
        rq = '{addr: 32'h40, we: 1'b0, be: 4'hF, wdata: 32'h0};
        next_cycle();
        set_idle();
        rst_i = 1'b1;
        drive_m0(1'b1, rq);
        s_gnt_i = 1'b1;
        s_rvalid_i = 1'b1;
        #1;
        n_tests++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_sreq_during: got %b want 0", s_req_o); end
        n_tests++; if (m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_during: got %b want 0", m0_gnt_o); end
        n_tests++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_during: got %b%b want 00", m1_rvalid_o, m0_rvalid_o); end
        next_cycle();
        rst_i = 1'b0;
        set_idle();
        #1;
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
        n_tests++; if (s_req_o !== 1'b0 || m0_gnt_o !== 1'b0 || m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_idle_outputs: got sreq=%b gnt=%b%b want 0", s_req_o, m1_gnt_o, m0_gnt_o); end
        n_tests++; if (s_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr_zero: got %h want 00000000", s_addr_o); end
    endtask

    // Plan 1: a lone m0 read with a one-cycle response. Leaves priority with m1.
    task automatic test_single_read();
        obi_req_t rq;
        rq = '{addr: 32'h100, we: 1'b0, be: 4'hF, wdata: 32'h0};
        drive_m0(1'b1, rq);
        s_gnt_i = 1'b1;
        #1;
        n_tests++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL single_gnt: got m0=%b m1=%b want m0=1 m1=0", m0_gnt_o, m1_gnt_o); end
        n_tests++; if (s_addr_o !== 32'h100 || s_be_o !== 4'hF || s_we_o !== 1'b0) begin n_fail++; $display("FAIL single_payload: got addr=%h be=%h we=%b want 00000100 f 0", s_addr_o, s_be_o, s_we_o); end
        next_cycle();
        m0_req_i = 1'b0;
        s_gnt_i = 1'b0;
        s_rvalid_i = 1'b1;
        s_rdata_i = 32'hDEADBEEF;
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b1 || m0_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_resp: got rvalid=%b rdata=%h want 1 deadbeef", m0_rvalid_o, m0_rdata_o); end
        n_tests++; if (m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_m1_rvalid: got %b want 0", m1_rvalid_o); end
        next_cycle();
        set_idle();
        #1;
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err_o); end
    endtask

    // Plan 3, entered with priority on m1: the stall lock must hold m0's
    // payload even though m1 would win arbitration otherwise.
    task automatic test_stall_lock();
        obi_req_t r0, r1;
        r0 = '{addr: 32'h200, we: 1'b1, be: 4'h3, wdata: 32'hCAFE0000};
        r1 = '{addr: 32'h300, we: 1'b0, be: 4'hF, wdata: 32'h0};
        drive_m0(1'b1, r0);
        s_gnt_i = 1'b0;
        #1;
        n_tests++; if (s_req_o !== 1'b1 || s_addr_o !== 32'h200 || m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL stall_c0: got sreq=%b addr=%h gnt=%b want 1 00000200 0", s_req_o, s_addr_o, m0_gnt_o); end
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            drive_m1(1'b1, r1);
            #1;
            n_tests++; if (s_addr_o !== 32'h200 || s_wdata_o !== 32'hCAFE0000 || m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL stall_hold_c%0d: got addr=%h wdata=%h m1gnt=%b want 00000200 cafe0000 0", c, s_addr_o, s_wdata_o, m1_gnt_o); end
        end
        next_cycle();
        s_gnt_i = 1'b1;
        #1;
        n_tests++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0 || s_addr_o !== 32'h200) begin n_fail++; $display("FAIL stall_release: got m0=%b m1=%b addr=%h want 1 0 00000200", m0_gnt_o, m1_gnt_o, s_addr_o); end
        next_cycle();
        m0_req_i = 1'b0;
        s_rvalid_i = 1'b1;
        s_rdata_i = 32'h11;
        #1;
        n_tests++; if (m1_gnt_o !== 1'b1 || s_addr_o !== 32'h300) begin n_fail++; $display("FAIL stall_m1_next: got m1gnt=%b addr=%h want 1 00000300", m1_gnt_o, s_addr_o); end
        n_tests++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL stall_resp_m0: got rvalid m0=%b m1=%b want 1 0", m0_rvalid_o, m1_rvalid_o); end
        next_cycle();
        m1_req_i = 1'b0;
        s_gnt_i = 1'b0;
        s_rdata_i = 32'h22;
        #1;
        n_tests++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0 || m1_rdata_o !== 32'h22) begin n_fail++; $display("FAIL stall_resp_m1: got rvalid m0=%b m1=%b rdata=%h want 0 1 00000022", m0_rvalid_o, m1_rvalid_o, m1_rdata_o); end
        next_cycle();
        set_idle();
    endtask

    // Plan 2: both masters request from reset; grants alternate starting at
    // m0 and each response lands one cycle after its grant.
    task automatic test_round_robin();
        obi_req_t r0, r1;
        logic exp_m0_gnt, exp_m0_rv, exp_m1_rv;
        r0 = '{addr: 32'h1000, we: 1'b0, be: 4'hF, wdata: 32'h0};
        r1 = '{addr: 32'h2000, we: 1'b0, be: 4'hF, wdata: 32'h0};
        drive_m0(1'b1, r0);
        drive_m1(1'b1, r1);
        s_gnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_rvalid_i = (k > 0);
            s_rdata_i  = 32'(k);
            exp_m0_gnt = (k % 2 == 0);
            exp_m0_rv  = (k > 0) && ((k - 1) % 2 == 0);
            exp_m1_rv  = (k > 0) && ((k - 1) % 2 == 1);
            #1;
            n_tests++; if (m0_gnt_o !== exp_m0_gnt || m1_gnt_o !== !exp_m0_gnt) begin n_fail++; $display("FAIL rr_gnt_c%0d: got m0=%b m1=%b want m0=%b m1=%b", k, m0_gnt_o, m1_gnt_o, exp_m0_gnt, !exp_m0_gnt); end
            n_tests++; if (s_addr_o !== (exp_m0_gnt ? 32'h1000 : 32'h2000)) begin n_fail++; $display("FAIL rr_addr_c%0d: got %h want %h", k, s_addr_o, exp_m0_gnt ? 32'h1000 : 32'h2000); end
            n_tests++; if (m0_rvalid_o !== exp_m0_rv || m1_rvalid_o !== exp_m1_rv) begin n_fail++; $display("FAIL rr_rvalid_c%0d: got m0=%b m1=%b want m0=%b m1=%b", k, m0_rvalid_o, m1_rvalid_o, exp_m0_rv, exp_m1_rv); end
            next_cycle();
        end
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
        s_rvalid_i = 1'b1;
        #1;
        n_tests++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got m0=%b m1=%b want 0 1", m0_rvalid_o, m1_rvalid_o); end
        next_cycle();
        set_idle();
        #1;
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b want 0", err_o); end
    endtask

    // Plan 4: two outstanding fills the FIFO; a response in a full cycle
    // does not open the port that same cycle.
    task automatic test_fifo_full();
        obi_req_t ra, rb, rc;
        ra = '{addr: 32'h400, we: 1'b0, be: 4'hF, wdata: 32'h0};
        rb = '{addr: 32'h500, we: 1'b0, be: 4'hF, wdata: 32'h0};
        rc = '{addr: 32'h408, we: 1'b0, be: 4'hF, wdata: 32'h0};
        drive_m0(1'b1, ra);
        s_gnt_i = 1'b1;
        #1;
        n_tests++; if (m0_gnt_o !== 1'b1) begin n_fail++; $display("FAIL full_gnt1: got %b want 1", m0_gnt_o); end
        next_cycle();
        m0_req_i = 1'b0;
        drive_m1(1'b1, rb);
        #1;
        n_tests++; if (m1_gnt_o !== 1'b1) begin n_fail++; $display("FAIL full_gnt2: got %b want 1", m1_gnt_o); end
        next_cycle();
        m1_req_i = 1'b0;
        drive_m0(1'b1, rc);
        #1;
        n_tests++; if (s_req_o !== 1'b0 || m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL full_block: got sreq=%b gnt=%b want 0 0", s_req_o, m0_gnt_o); end
        next_cycle();
        s_rvalid_i = 1'b1;
        s_rdata_i = 32'hA;
        #1;
        n_tests++; if (s_req_o !== 1'b0 || m0_gnt_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_block: got sreq=%b gnt=%b want 0 0", s_req_o, m0_gnt_o); end
        n_tests++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_route: got m0=%b m1=%b want 1 0", m0_rvalid_o, m1_rvalid_o); end
        next_cycle();
        s_rvalid_i = 1'b0;
        #1;
        n_tests++; if (s_req_o !== 1'b1 || m0_gnt_o !== 1'b1 || s_addr_o !== 32'h408) begin n_fail++; $display("FAIL full_resume: got sreq=%b gnt=%b addr=%h want 1 1 00000408", s_req_o, m0_gnt_o, s_addr_o); end
        next_cycle();
        m0_req_i = 1'b0;
        s_gnt_i = 1'b0;
        s_rvalid_i = 1'b1;
        #1;
        n_tests++; if (m1_rvalid_o !== 1'b1 || m0_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL full_order_m1: got m0=%b m1=%b want 0 1", m0_rvalid_o, m1_rvalid_o); end
        next_cycle();
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b1 || m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL full_order_m0: got m0=%b m1=%b want 1 0", m0_rvalid_o, m1_rvalid_o); end
        next_cycle();
        set_idle();
        #1;
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b want 0", err_o); end
    endtask

    // Plan 5: a response with nothing outstanding is flagged and sticks.
    task automatic test_err_empty();
        s_rvalid_i = 1'b1;
        s_rdata_i = 32'h55;
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL err_no_rvalid: got m0=%b m1=%b want 0 0", m0_rvalid_o, m1_rvalid_o); end
        next_cycle();
        s_rvalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky_c%0d: got %b want 1", c, err_o); end
            next_cycle();
        end
        do_reset();
        #1;
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err_o); end
    endtask

    // Plan 6: reset with an m0 transaction in flight drops its ID and
    // returns priority to m0.
    task automatic test_reset_inflight();
        obi_req_t r0, r1;
        r0 = '{addr: 32'h600, we: 1'b0, be: 4'hF, wdata: 32'h0};
        r1 = '{addr: 32'h700, we: 1'b0, be: 4'hF, wdata: 32'h0};
        drive_m0(1'b1, r0);
        s_gnt_i = 1'b1;
        #1;
        n_tests++; if (m0_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rst_inflight_gnt: got %b want 1", m0_gnt_o); end
        next_cycle();
        m0_req_i = 1'b0;
        drive_m1(1'b1, r1);
        rst_i = 1'b1;
        #1;
        n_tests++; if (m1_gnt_o !== 1'b0 || s_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_quiet: got gnt=%b sreq=%b want 0 0", m1_gnt_o, s_req_o); end
        next_cycle();
        rst_i = 1'b0;
        m1_req_i = 1'b0;
        s_gnt_i = 1'b0;
        s_rvalid_i = 1'b1;
        #1;
        n_tests++; if (m0_rvalid_o !== 1'b0 || m1_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid: got m0=%b m1=%b want 0 0", m0_rvalid_o, m1_rvalid_o); end
        next_cycle();
        s_rvalid_i = 1'b0;
        drive_m0(1'b1, r0);
        drive_m1(1'b1, r1);
        s_gnt_i = 1'b1;
        #1;
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL rst_late_err: got %b want 1", err_o); end
        n_tests++; if (m0_gnt_o !== 1'b1 || m1_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_prio_m0: got m0=%b m1=%b want 1 0", m0_gnt_o, m1_gnt_o); end
        next_cycle();
        set_idle();
    endtask

    initial begin
        rst_i = 1'b1;
        set_idle();
        test_reset();
        test_single_read();
        test_stall_lock();
        do_reset();
        test_round_robin();
        do_reset();
        test_fifo_full();
        do_reset();
        test_err_empty();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
